mem_noc_dec_1to2: RTL

MEM_NOC_DEC_1TO2 -- requirements
Module: mem_noc_dec_1to2

---
 rtl/mem_noc_dec_1to2.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_noc_dec_1to2.sv
// 1-to-2 memory NoC address decoder with in-order response routing FIFO.
// Define MEM_NOC_DEC_STAT_EN to add the saturating stall_cnt statistics output.
package mem_noc_pkg;
  typedef struct packed {
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_data;
    logic        resp_last;
  } mem_resp_t;
endpackage

module mem_noc_dec_1to2
  import mem_noc_pkg::*;
#(
  parameter logic [31:0] SN1_BASE = 32'h1000_0000,
  parameter logic [31:0] SN1_MASK = 32'hF000_0000,
  parameter int          MAX_OS   = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      mn_req_valid,
  output logic      mn_req_ready,
  input  mem_req_t  mn_req,
  output logic      mn_resp_valid,
  input  logic      mn_resp_ready,
  output mem_resp_t mn_resp,
  output logic      sn0_req_valid,
  input  logic      sn0_req_ready,
  output mem_req_t  sn0_req,
  input  logic      sn0_resp_valid,
  output logic      sn0_resp_ready,
  input  mem_resp_t sn0_resp,
  output logic      sn1_req_valid,
  input  logic      sn1_req_ready,
  output mem_req_t  sn1_req,
  input  logic      sn1_resp_valid,
  output logic      sn1_resp_ready,
  input  mem_resp_t sn1_resp
`ifdef MEM_NOC_DEC_STAT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_OS + 1);
  localparam int PTR_W = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
  localparam logic [CNT_W-1:0] OS_FULL  = CNT_W'(MAX_OS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OS - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0]  os_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  yng_ptr;
  logic [MAX_OS-1:0] route_q;
  logic              tgt;
  logic              empty;
  logic              stall;
  logic              head_tgt;
  logic              push;
  logic              pop;

  assign tgt      = ((mn_req.req_addr & SN1_MASK) == SN1_BASE);
  assign empty    = (os_cnt == '0);
  assign yng_ptr  = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
  assign head_tgt = route_q[rd_ptr];

  // A new request may only follow outstanding ones to the same slave, so responses stay ordered.
  assign stall = (os_cnt == OS_FULL) || (!empty && (route_q[yng_ptr] != tgt));

  assign mn_req_ready  = !rst && !stall && (tgt ? sn1_req_ready : sn0_req_ready);
  assign sn0_req_valid = !rst && mn_req_valid && !tgt && !stall;
  assign sn1_req_valid = !rst && mn_req_valid &&  tgt && !stall;
  assign sn0_req       = mn_req;
  assign sn1_req       = mn_req;

  always_comb begin
    mn_resp_valid  = 1'b0;
    mn_resp        = '0;
    sn0_resp_ready = 1'b0;
    sn1_resp_ready = 1'b0;
    if (!empty) begin
      if (head_tgt) begin
        mn_resp_valid  = sn1_resp_valid;
        mn_resp        = sn1_resp;
        sn1_resp_ready = mn_resp_ready;
      end else begin
        mn_resp_valid  = sn0_resp_valid;
        mn_resp        = sn0_resp;
        sn0_resp_ready = mn_resp_ready;
      end
    end
  end

  assign push = mn_req_valid && mn_req_ready;
  // Only the last beat retires an entry, so a burst keeps its route until it completes.
  assign pop  = mn_resp_valid && mn_resp_ready && mn_resp.resp_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      route_q <= '0;
    end else begin
      if (push) begin
        route_q[wr_ptr] <= tgt;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   os_cnt <= os_cnt + CNT_W'(1);
        2'b01:   os_cnt <= os_cnt - CNT_W'(1);
        default: os_cnt <= os_cnt;
      endcase
    end
  end

`ifdef MEM_NOC_DEC_STAT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (mn_req_valid && stall) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end
`endif

endmodule
